sum_stage_pipe: RTL and testbench
=================================

SUM_STAGE_PIPE -- requirements
Module: sum_stage_pipe

Interface
REQ-001 Parameter: width, default 10, operand bit count; legal range 2..64; all vectors indexed [width:1], bit 1 = LSB.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream presents a valid p/G/P/cin set.
REQ-005 in_ready  output  1  block accepts input this cycle.
REQ-006 p  input  width  per-bit propagate (a^b) from the pg stage.
REQ-007 G  input  width  group generate, G[i] = generate of bits i..1, from the prefix stage.
REQ-008 P  input  width  group propagate, P[i] = propagate of bits i..1, from the prefix stage.
REQ-009 cin  input  1  carry-in of the addition.
REQ-010 out_valid  output  1  sum/cout/ovf hold a valid result.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 sum  output  width  registered sum.
REQ-013 cout  output  1  registered carry out of bit width.
REQ-014 ovf  output  1  registered two's-complement overflow.
REQ-015 op_count  output  8  saturating count of results delivered.

Function
REQ-016 Carries: c[0] = cin; c[i] = G[i] | (P[i] & cin) for i = 1..width.
REQ-017 sum[i] = p[i] ^ c[i-1]; cout = c[width]; ovf = c[width] ^ c[width-1].
REQ-018 Two pipeline registers: stage A captures p and c[width:0] on input handshake; stage B captures sum/cout/ovf from stage A.
REQ-019 Input handshake occurs when in_valid & in_ready; output handshake when out_valid & out_ready.
REQ-020 Latency: result of an accepted input appears on outputs with out_valid high exactly 2 cycles after acceptance when no backpressure.
REQ-021 Stage B loads when stage A valid and (stage B empty or output handshake this cycle).
REQ-022 in_ready = !A_valid | (A moves to B this cycle); combinational from state and out_ready only, never from in_valid.
REQ-023 Throughput: one result per cycle while out_ready held high.
REQ-024 Backpressure: with out_ready low, outputs and out_valid hold stable; pipeline fills to 2 entries then in_ready drops; no data lost or duplicated.
REQ-025 Simultaneous output handshake and input handshake when full: both stages advance in the same cycle.
REQ-026 op_count increments by 1 on each output handshake; saturates at 255.
REQ-027 Inputs p/G/P/cin are don't-care when in_valid low; must not affect state.

Reset
REQ-028 On rst high at a clock edge: A_valid = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0, op_count = 0; in-flight data discarded.
REQ-029 in_ready is 1 in the first cycle after reset deasserts.
REQ-030 Reset mid-transfer overrides any concurrent handshake; no result from before reset is ever presented.

Structure
REQ-031 Shared package holds the op_count width (8) and its saturation limit; width stays a module parameter.
REQ-032 One sub-module is natural: carry_sel (combinational c[width:0] from G/P/cin, same [width:1] convention as the prefix stages).
REQ-033 No latches; all registers reset per REQ-028.

Verification
REQ-034 width=10, a=0x3FF, b=0x001, cin=0 (p=0x3FE, G/P from a reference prefix model) -> 2 cycles later sum=0x000, cout=1, ovf=0.
REQ-035 a=0x1FF, b=0x001, cin=0 -> sum=0x200, cout=0, ovf=1; a=0x200, b=0x200, cin=0 -> sum=0x000, cout=1, ovf=1.
REQ-036 a=0x000, b=0x000, cin=1 -> sum=0x001, cout=0, ovf=0.
REQ-037 Stream 5 inputs with out_ready=0 -> exactly 2 accepted, in_ready=0, outputs stable; raise out_ready -> remaining 3 accepted, 5 results in order, op_count=5.
REQ-038 Assert rst with 2 entries in flight -> next cycle out_valid=0, op_count=0, in_ready=1; no stale result appears.
REQ-039 Random a/b/cin for 10,000 transactions with random valid/ready toggling versus a+b+cin golden model -> zero mismatches; op_count saturates at 255.

Source files
------------

// File: rtl/sum_stage_pipe_pkg.sv
// Shared definitions for the sum stage of the prefix adder.
// Holds the delivered-result counter width and its saturating step.
package sum_stage_pipe_pkg;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sum_stage_pipe_carry_sel.sv
// Final carry selection of a parallel-prefix adder.
// c[i] is the carry out of bit i; c[0] is the adder carry-in.
module sum_stage_pipe_carry_sel #(
    parameter int width = 10
) (
    input  logic [width:1] G,
    input  logic [width:1] P,
    input  logic           cin,
    output logic [width:0] c
);

    assign c = {G | (P & {width{cin}}), cin};

endmodule

// File: rtl/sum_stage_pipe.sv
// Two-stage registered sum stage with valid/ready flow control.
// Stage A holds p and carries, stage B holds the final result.
module sum_stage_pipe
    import sum_stage_pipe_pkg::*;
#(
    parameter int width = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width:1]   p,
    input  logic [width:1]   G,
    input  logic [width:1]   P,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width:1]   sum,
    output logic             cout,
    output logic             ovf,
    output logic [CNT_W-1:0] op_count
);

    logic           a_valid;
    logic [width:1] a_p;
    logic [width:0] a_c;
    logic [width:0] c;

    logic in_hs;
    logic out_hs;
    logic b_load;

    sum_stage_pipe_carry_sel #(
        .width(width)
    ) u_carry_sel (
        .G  (G),
        .P  (P),
        .cin(cin),
        .c  (c)
    );

    assign out_hs   = out_valid & out_ready;
    assign b_load   = a_valid & (~out_valid | out_ready);
    assign in_ready = ~a_valid | b_load;
    assign in_hs    = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0;
            a_p     <= '0;
            a_c     <= '0;
        end else if (in_hs) begin
            a_valid <= 1'b1;
            a_p     <= p;
            a_c     <= c;
        end else if (b_load) begin
            a_valid <= 1'b0;
        end
    end

    // sum[i] pairs p[i] with the carry into bit i, c[i-1]
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (b_load) begin
            out_valid <= 1'b1;
            sum       <= a_p ^ a_c[width-1:0];
            cout      <= a_c[width];
            ovf       <= a_c[width] ^ a_c[width-1];
        end else if (out_hs) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (out_hs) begin
            op_count <= sat_inc(op_count);
        end
    end

endmodule

// File: tb/tb_sum_stage_pipe.sv
// Self-checking bench for sum_stage_pipe at width 10.
// Golden results come from plain a+b+cin arithmetic.
module tb_sum_stage_pipe;

    typedef struct {
        logic [9:0] sum;
        logic       cout;
        logic       ovf;
    } res_t;

    typedef struct {
        logic [9:0] a;
        logic [9:0] b;
        logic       cin;
        logic [9:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [10:1] p;
    logic [10:1] G;
    logic [10:1] P;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [10:1] sum;
    logic        cout;
    logic        ovf;
    logic [7:0]  op_count;

    int errors = 0;
    int checks = 0;
    int n_in   = 0;
    int n_out  = 0;

    logic [9:0] cur_a;
    logic [9:0] cur_b;
    logic       cur_cin;

    res_t q[$];

    logic       prev_stall = 1'b0;
    logic [9:0] prev_sum;
    logic       prev_cout;
    logic       prev_ovf;

    always #5 clk = ~clk;

    sum_stage_pipe #(
        .width(10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .p        (p),
        .G        (G),
        .P        (P),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .op_count (op_count)
    );

    function automatic res_t gold(
        input logic [9:0] a,
        input logic [9:0] b,
        input logic       ci
    );
        logic [10:0] s;
        res_t r;
        s      = {1'b0, a} + {1'b0, b} + {10'd0, ci};
        r.sum  = s[9:0];
        r.cout = s[10];
        r.ovf  = (a[9] == b[9]) && (s[9] != a[9]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference pg + serial prefix model feeding the DUT
    task automatic drive(input logic [9:0] a, input logic [9:0] b,
                         input logic ci);
        logic [9:0] g, pp, gg, ppg;
        g      = a & b;
        pp     = a ^ b;
        gg[0]  = g[0];
        ppg[0] = pp[0];
        for (int i = 1; i < 10; i++) begin
            gg[i]  = g[i] | (pp[i] & gg[i-1]);
            ppg[i] = pp[i] & ppg[i-1];
        end
        p       = pp;
        G       = gg;
        P       = ppg;
        cin     = ci;
        cur_a   = a;
        cur_b   = b;
        cur_cin = ci;
    endtask

    // called at posedge+1; returns at posedge+1
    task automatic send(input logic [9:0] a, input logic [9:0] b,
                        input logic ci, input int bound,
                        output bit ok);
        ok = 1'b0;
        drive(a, b, ci);
        in_valid = 1'b1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!out_valid || sum != prev_sum ||
                    cout != prev_cout || ovf != prev_ovf) begin
                    errors++;
                    $display("FAIL hold: got v=%0b s=%0h expected v=1 s=%0h",
                             out_valid, sum, prev_sum);
                end
            end
            if (out_valid && out_ready) begin
                n_out++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got s=%0h expected none",
                             sum);
                end else begin
                    res_t e;
                    e = q.pop_front();
                    if (sum != e.sum || cout != e.cout || ovf != e.ovf) begin
                        errors++;
                        if (errors < 20)
                            $display("FAIL result: got %0h/%0b/%0b expected %0h/%0b/%0b",
                                     sum, cout, ovf, e.sum, e.cout, e.ovf);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(gold(cur_a, cur_b, cur_cin));
                n_in++;
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = sum;
            prev_cout  = cout;
            prev_ovf   = ovf;
        end
    end

    initial begin
        vec_t vt[8];
        bit ok;
        int n;
        int base_in;
        int base_out;
        int acc;

        vt[0] = '{10'h3FF, 10'h001, 1'b0, 10'h000, 1'b1, 1'b0};
        vt[1] = '{10'h1FF, 10'h001, 1'b0, 10'h200, 1'b0, 1'b1};
        vt[2] = '{10'h200, 10'h200, 1'b0, 10'h000, 1'b1, 1'b1};
        vt[3] = '{10'h000, 10'h000, 1'b1, 10'h001, 1'b0, 1'b0};
        vt[4] = '{10'h155, 10'h2AA, 1'b0, 10'h3FF, 1'b0, 1'b0};
        vt[5] = '{10'h3FF, 10'h3FF, 1'b1, 10'h3FF, 1'b1, 1'b0};
        vt[6] = '{10'h1FF, 10'h1FF, 1'b1, 10'h3FF, 1'b0, 1'b1};
        vt[7] = '{10'h123, 10'h0DC, 1'b1, 10'h200, 1'b0, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(10'h0, 10'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int k = 0; k < 8; k++) begin
            send(vt[k].a, vt[k].b, vt[k].cin, 4, ok);
            chk($sformatf("vec%0d_accept", k), 32'(ok), 32'd1);
            n = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                n++;
                if (out_valid) break;
            end
            chk($sformatf("vec%0d_latency", k), 32'(n), 32'd2);
            chk($sformatf("vec%0d_sum", k), 32'(sum), 32'(vt[k].sum));
            chk($sformatf("vec%0d_cout", k), 32'(cout), 32'(vt[k].cout));
            chk($sformatf("vec%0d_ovf", k), 32'(ovf), 32'(vt[k].ovf));
            @(posedge clk);
            #1;
        end

        acc = 0;
        for (int k = 0; k < 6; k++) begin
            send(vt[k].a, vt[k].b, vt[k].cin, 1, ok);
            if (ok) acc++;
        end
        in_valid = 1'b0;
        chk("stream_accepts", 32'(acc), 32'd6);
        repeat (4) @(posedge clk);
        #1;

        do_reset();
        base_in   = n_in;
        base_out  = n_out;
        out_ready = 1'b0;
        send(vt[0].a, vt[0].b, vt[0].cin, 4, ok);
        send(vt[1].a, vt[1].b, vt[1].cin, 4, ok);
        send(vt[2].a, vt[2].b, vt[2].cin, 4, ok);
        chk("bp_third_stalled", 32'(ok), 32'd0);
        @(negedge clk);
        chk("bp_accepted", 32'(n_in - base_in), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_head_sum", 32'(sum), 32'(vt[0].sum));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(vt[2].a, vt[2].b, vt[2].cin, 4, ok);
        chk("bp_resume", 32'(ok), 32'd1);
        send(vt[3].a, vt[3].b, vt[3].cin, 4, ok);
        send(vt[4].a, vt[4].b, vt[4].cin, 4, ok);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (n_out - base_out == 5 && q.size() == 0) break;
        end
        chk("bp_delivered", 32'(n_out - base_out), 32'd5);
        chk("bp_op_count", 32'(op_count), 32'd5);
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(vt[5].a, vt[5].b, vt[5].cin, 4, ok);
        send(vt[6].a, vt[6].b, vt[6].cin, 4, ok);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_op_count", 32'(op_count), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        base_out  = n_out;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_rst_no_stale", 32'(n_out - base_out), 32'd0);
        @(posedge clk);
        #1;

        do_reset();
        base_in  = n_in;
        base_out = n_out;
        for (int c = 0; c < 80000 && (n_in - base_in) < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            drive(10'($urandom), 10'($urandom), 1'($urandom_range(0, 1)));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        chk("rand_accepted", 32'(n_in - base_in), 32'd10000);
        chk("rand_delivered", 32'(n_out - base_out), 32'd10000);
        chk("rand_drained", 32'(q.size()), 32'd0);
        chk("rand_op_count_sat", 32'(op_count), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
